// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide initiator: op codes,
// controller states and op-class helpers.
package hilo_pkg;

  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_MULTU = 4'b0110;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b0111;
  localparam logic [3:0] OP_MTHI  = 4'b1000;
  localparam logic [3:0] OP_MTLO  = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL_WAIT = 2'd1,
    S_DIV_WAIT = 2'd2
  } hilo_state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// EX-stage initiator for the mul/div unit: launches it, stalls the pipe until
// the result is back, then commits architectural HI/LO. Optional macro
// HILO_DIVZERO_SKIP_EN turns divide-by-zero into an unlaunched no-op.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  output logic [3:0]       au_op,
  output logic             au_start,
  output logic             au_abort,
  input  logic [WIDTH-1:0] au_hi,
  input  logic [WIDTH-1:0] au_lo,
  input  logic             au_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall
);

  localparam int unsigned CW = (MUL_LAT < 1) ? 1 : $clog2(MUL_LAT + 1);

  hilo_state_e      r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_au_a, r_au_b, r_hi, r_lo;
  logic [3:0]       r_au_op;
  logic             r_au_start, r_au_abort;

  logic             w_accept, w_div_skip, w_launch, w_abort_nxt;
  logic             w_hi_we, w_lo_we, w_stall;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

  always_comb begin
`ifdef HILO_DIVZERO_SKIP_EN
    w_div_skip = is_div(op) && (rt_data == '0);
`else
    w_div_skip = 1'b0;
`endif
    w_accept    = (r_state == S_IDLE) && op_valid && !flush;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_launch    = 1'b0;
    w_abort_nxt = 1'b0;
    w_hi_we     = 1'b0;
    w_lo_we     = 1'b0;
    w_hi_nxt    = au_hi;
    w_lo_nxt    = au_lo;
    w_stall     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (is_mul(op)) begin
            w_state_nxt = S_MUL_WAIT;
            w_cnt_nxt   = CW'(MUL_LAT);
            w_launch    = 1'b1;
            w_stall     = 1'b1;
          end else if (is_div(op) && !w_div_skip) begin
            w_state_nxt = S_DIV_WAIT;
            w_launch    = 1'b1;
            w_stall     = 1'b1;
          end else if (op == OP_MTHI) begin
            w_hi_we  = 1'b1;
            w_hi_nxt = rs_data;
          end else if (op == OP_MTLO) begin
            w_lo_we  = 1'b1;
            w_lo_nxt = rs_data;
          end
        end
      end
      // Flush is checked first in both wait states so it beats a same-cycle commit.
      S_MUL_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_abort_nxt = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_hi_we     = 1'b1;
          w_lo_we     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          w_stall   = 1'b1;
        end
      end
      S_DIV_WAIT: begin
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_abort_nxt = 1'b1;
        end else if (au_done) begin
          w_state_nxt = S_IDLE;
          w_hi_we     = 1'b1;
          w_lo_we     = 1'b1;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_au_a     <= '0;
      r_au_b     <= '0;
      r_au_op    <= '0;
      r_au_start <= 1'b0;
      r_au_abort <= 1'b0;
    end else begin
      r_au_start <= w_launch;
      r_au_abort <= w_abort_nxt;
      if (w_launch) begin
        r_au_a  <= rs_data;
        r_au_b  <= rt_data;
        r_au_op <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_nxt;
      if (w_lo_we) r_lo <= w_lo_nxt;
    end
  end

  assign au_a     = r_au_a;
  assign au_b     = r_au_b;
  assign au_op    = r_au_op;
  assign au_start = r_au_start;
  assign au_abort = r_au_abort;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign stall    = w_stall && resetn;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a small behavioural mul/div unit model.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        resetn, op_valid, flush, au_done;
  logic [3:0]  op;
  logic [31:0] rs_data, rt_data;
  logic [31:0] au_a, au_b, au_hi, au_lo, hi, lo;
  logic [3:0]  au_op;
  logic        au_start, au_abort, stall;

  int n_chk = 0;
  int n_pass = 0;
  int n_start = 0;
  int n_abort = 0;
  int n_stall = 0;
  int s0, a0, t0;

  hilo_ctrl #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_start(au_start),
    .au_abort(au_abort), .au_hi(au_hi), .au_lo(au_lo), .au_done(au_done),
    .hi(hi), .lo(lo), .stall(stall)
  );

  always #5 clk = ~clk;

  // Unit model: result is latched on au_start and held until the next launch.
  always @(posedge clk) begin
    logic [63:0] p;
    if (au_start) begin
      case (au_op)
        OP_MULT: begin
          p = {{32{au_a[31]}}, au_a} * {{32{au_b[31]}}, au_b};
          au_hi <= p[63:32];
          au_lo <= p[31:0];
        end
        OP_MULTU: begin
          p = {32'b0, au_a} * {32'b0, au_b};
          au_hi <= p[63:32];
          au_lo <= p[31:0];
        end
        OP_DIV: begin
          if (au_b == 0) begin au_hi <= au_a; au_lo <= '1; end
          else begin
            au_hi <= $signed(au_a) % $signed(au_b);
            au_lo <= $signed(au_a) / $signed(au_b);
          end
        end
        default: begin
          if (au_b == 0) begin au_hi <= au_a; au_lo <= '1; end
          else begin au_hi <= au_a % au_b; au_lo <= au_a / au_b; end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (au_start) n_start++;
    if (au_abort) n_abort++;
    if (stall)    n_stall++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    rs_data  = a;
    rt_data  = b;
  endtask

  // Accept in cycle T, drop op_valid, and stop after the commit edge (T+7).
  task automatic run_mul(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    step();
    op_valid = 1'b0;
    repeat (6) step();
  endtask

  initial begin
    resetn = 1'b0; op_valid = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; au_done = 1'b0;
    repeat (2) step();
    issue(OP_MULT, 32'h1, 32'h1);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_au_a", au_a, 0);
    chk("rst_au_b", au_b, 0);
    chk("rst_au_op", au_op, 0);
    chk("rst_start", au_start, 0);
    chk("rst_abort", au_abort, 0);
    chk("rst_stall_forced", stall, 0);
    op_valid = 1'b0;
    resetn = 1'b1;
    step();

    // MULT -2 * 3
    s0 = n_start; t0 = n_stall;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    #1;
    chk("mul_T_stall", stall, 1);
    chk("mul_T_start", au_start, 0);
    step();
    op_valid = 1'b0;
    #1;
    chk("mul_T1_start", au_start, 1);
    chk("mul_T1_op", au_op, OP_MULT);
    chk("mul_T1_a", au_a, 32'hFFFF_FFFE);
    repeat (5) step();
    #1;
    chk("mul_commit_stall", stall, 0);
    chk("mul_pre_hi", hi, 0);
    step();
    #1;
    chk("mul_hi", hi, 32'hFFFF_FFFF);
    chk("mul_lo", lo, 32'hFFFF_FFFA);
    chk("mul_stall_cycles", n_stall - t0, 6);
    chk("mul_start_pulses", n_start - s0, 1);

    // DIVU 100 / 7, au_done 33 cycles after start
    t0 = n_stall;
    issue(OP_DIVU, 32'd100, 32'd7);
    step();
    op_valid = 1'b0;
    repeat (33) step();
    au_done = 1'b1;
    #1;
    chk("divu_done_stall", stall, 0);
    step();
    au_done = 1'b0;
    #1;
    chk("divu_lo", lo, 14);
    chk("divu_hi", hi, 2);
    chk("divu_stall_cycles", n_stall - t0, 34);

    // MTHI then MTLO back to back
    t0 = n_stall;
    issue(OP_MTHI, 32'h1234, 32'h0);
    #1;
    chk("mthi_stall", stall, 0);
    step();
    issue(OP_MTLO, 32'h5678, 32'h0);
    #1;
    chk("mthi_hi_T1", hi, 32'h1234);
    chk("mtlo_lo_T1_old", lo, 14);
    step();
    op_valid = 1'b0;
    #1;
    chk("mtlo_lo_T2", lo, 32'h5678);
    chk("mt_stall_never", n_stall - t0, 0);

    // Flush 10 cycles into a DIV, then a late au_done
    a0 = n_abort;
    issue(OP_DIV, 32'd50, 32'd5);
    step();
    op_valid = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_abort_early", au_abort, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_abort", au_abort, 1);
    step();
    #1;
    chk("flush_abort_once", au_abort, 0);
    chk("flush_hi_kept", hi, 32'h1234);
    chk("flush_lo_kept", lo, 32'h5678);
    repeat (3) step();
    au_done = 1'b1;
    #1;
    chk("late_done_stall", stall, 0);
    step();
    au_done = 1'b0;
    #1;
    chk("late_done_hi", hi, 32'h1234);
    chk("late_done_lo", lo, 32'h5678);
    chk("flush_abort_count", n_abort - a0, 1);
    run_mul(OP_MULTU, 32'd7, 32'd9);
    chk("post_flush_mul_hi", hi, 0);
    chk("post_flush_mul_lo", lo, 63);

    // Flush and au_done in the same cycle
    issue(OP_DIVU, 32'd9, 32'd2);
    step();
    op_valid = 1'b0;
    repeat (4) step();
    au_done = 1'b1;
    flush   = 1'b1;
    #1;
    chk("flush_done_stall", stall, 0);
    step();
    au_done = 1'b0;
    flush   = 1'b0;
    #1;
    chk("flush_done_hi", hi, 0);
    chk("flush_done_lo", lo, 63);
    chk("flush_done_abort", au_abort, 1);

    // Flush on the accept cycle: no MTHI write, no launch
    s0 = n_start;
    issue(OP_MTHI, 32'hDEAD, 32'h0);
    flush = 1'b1;
    #1;
    chk("acc_flush_mthi_stall", stall, 0);
    step();
    issue(OP_MULT, 32'd3, 32'd3);
    #1;
    chk("acc_flush_mthi_hi", hi, 0);
    chk("acc_flush_mul_stall", stall, 0);
    step();
    flush = 1'b0;
    op_valid = 1'b0;
    step();
    #1;
    chk("acc_flush_no_start", n_start - s0, 0);
    chk("acc_flush_au_a", au_a, 9);

    // Unknown op code
    issue(4'b0000, 32'hBEEF, 32'd1);
    #1;
    chk("unk_stall", stall, 0);
    step();
    op_valid = 1'b0;
    #1;
    chk("unk_start", au_start, 0);
    chk("unk_hi", hi, 0);
    chk("unk_lo", lo, 63);

    // Divide by zero
    s0 = n_start;
    issue(OP_DIV, 32'h55, 32'h0);
    #1;
`ifdef HILO_DIVZERO_SKIP_EN
    chk("div0_stall", stall, 0);
    step();
    issue(OP_MTHI, 32'h77, 32'h0);
    #1;
    chk("div0_start", au_start, 0);
    step();
    op_valid = 1'b0;
    #1;
    chk("div0_lo_kept", lo, 63);
    chk("div0_idle_mthi", hi, 32'h77);
    chk("div0_no_start", n_start - s0, 0);
`else
    chk("div0_stall", stall, 1);
    step();
    op_valid = 1'b0;
    #1;
    chk("div0_start", au_start, 1);
    repeat (3) step();
    au_done = 1'b1;
    step();
    au_done = 1'b0;
    #1;
    chk("div0_hi", hi, 32'h55);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
`endif

    // Reset during MUL_WAIT
    a0 = n_abort;
    issue(OP_MULT, 32'd5, 32'd5);
    step();
    op_valid = 1'b0;
    step();
    resetn = 1'b0;
    #1;
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_au_a", au_a, 0);
    chk("midrst_au_op", au_op, 0);
    chk("midrst_start", au_start, 0);
    step();
    step();
    resetn = 1'b1;
    repeat (8) step();
    chk("midrst_no_abort", n_abort - a0, 0);
    chk("midrst_lo_stays0", lo, 0);
    issue(OP_MTLO, 32'hA5, 32'h0);
    step();
    op_valid = 1'b0;
    #1;
    chk("midrst_mtlo", lo, 32'hA5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

- Pipeline-side initiator for the multiply/divide unit in the EX stage of the MIPS core.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and launches the arithmetic unit with a start pulse.
- Holds `stall` until the result is available, then commits it to the architectural HI/LO registers.
- Aborts cleanly on pipeline flush.

## Interface
Parameters:
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_LAT`, 5: cycles from `au_start` to a valid multiply result (≥1).

Ports:
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `op_valid` in 1: EX presents an instruction for this block.
- `op` in 4: 0101 MULT, 0110 MULTU, 1011 DIV, 0111 DIVU, 1000 MTHI, 1001 MTLO; other codes are ignored.
- `rs_data`, `rt_data` in WIDTH: operands, with rs as dividend/multiplicand.
- `flush` in 1: exception or eret flush; kills the current and in-flight operation.
- `au_a`, `au_b` out WIDTH: registered operands to the unit.
- `au_op` out 4: registered op code to the unit.
- `au_start` out 1: one-cycle launch pulse.
- `au_abort` out 1: one-cycle cancel pulse.
- `au_hi`, `au_lo` in WIDTH: unit result; for divide, hi = remainder and lo = quotient.
- `au_done` in 1: divider result valid, a single-cycle pulse.
- `hi`, `lo` out WIDTH: architectural HI/LO, read directly by MFHI/MFLO.
- `stall` out 1: freeze IF..EX.

## Operation
States: IDLE, MUL_WAIT, DIV_WAIT.

- **Accept:** IDLE & `op_valid` & !`flush`.
  - MULT/MULTU: go to MUL_WAIT, `cnt` ← MUL_LAT.
  - DIV/DIVU: go to DIV_WAIT.
  - In both cases register `au_a`/`au_b`/`au_op` and pulse `au_start` in the next cycle.
  - MTHI/MTLO: write `rs_data` into `hi`/`lo` at that clock edge. No state change, no stall.
- **MUL_WAIT:** `cnt` decrements each cycle after `au_start`. When `cnt`==0, `au_hi`/`au_lo` are written into `hi`/`lo` at that edge and the block returns to IDLE.
- **DIV_WAIT:** on `au_done`, write `hi`/`lo` from `au_hi`/`au_lo` and return to IDLE. There is no timeout.
- **Stall:** `stall` = (IDLE & `op_valid` & mul/div op & !`flush`) | (MUL_WAIT & `cnt`!=0) | (DIV_WAIT & !`au_done`). It is combinational and drops in the commit cycle, so the EX instruction retires on the same edge that HI/LO update.
- **Flush in a WAIT state:** go to IDLE, no HI/LO write, pulse `au_abort` the next cycle, `stall`=0 in the flush cycle. `au_done` arriving while in IDLE is ignored.
- **Simultaneous flush and `au_done` (or `cnt`==0):** flush wins; no write.
- **Flush on the accept cycle:** no launch; MTHI/MTLO are not written.
- **Unknown op codes:** no effect.

## Timing
Reset values (asynchronous, `resetn` low):
- `hi`, `lo`, `au_a`, `au_b`, `au_op` = 0.
- `au_start`, `au_abort` = 0.
- State = IDLE, `cnt` = 0.
- `stall` is forced to 0 while `resetn` is low.
- Reset mid-operation abandons it silently; no `au_abort` is issued.

Cycle numbering (accept cycle = T):
- `au_start` is high in T+1.
- Multiply commit edge is at the end of T+1+MUL_LAT; `stall` is high for T..T+MUL_LAT and low in T+1+MUL_LAT.
- Divide commit is at the end of the `au_done` cycle.
- MTHI/MTLO are visible on `hi`/`lo` at T+1.

## Configuration
`HILO_DIVZERO_SKIP_EN`:
- **Defined:** DIV/DIVU with `rt_data`==0 is accepted without launching the unit. There is no stall, no `au_start`, and HI/LO are unchanged, matching MIPS UNPREDICTABLE → no-op.
- **Undefined:** divide by zero launches normally and commits whatever the unit returns.

## Structure
- Shared package `hilo_pkg`:
  - op-code localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO);
  - state encoding enum;
  - helper functions `is_mul(op)` and `is_div(op)`.
- No sub-module; the counter and FSM are small and live in one file.

## Test plan
- **MULT:** `rs`=0xFFFFFFFE, `rt`=3, MUL_LAT=5.
  - `au_start` at T+1; `stall` high for exactly 6 cycles.
  - With the unit model returning a signed product, `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA at T+7.
- **DIVU:** `rs`=100, `rt`=7; `au_done` pulsed 33 cycles after start.
  - `stall` drops in the `au_done` cycle; `lo`=14, `hi`=2 the cycle after.
- **MTHI then MTLO** back-to-back with 0x1234 and 0x5678 → `hi`=0x1234 at T+1, `lo`=0x5678 at T+2, `stall` never asserted.
- **Flush** 10 cycles into a DIV:
  - state returns to IDLE, `au_abort` pulses once, HI/LO keep their old values;
  - a late `au_done` is ignored;
  - a following MULT commits correctly.
- **Flush and `au_done` in the same cycle** → no HI/LO write, `stall` low.
- **`resetn` asserted during MUL_WAIT:**
  - all outputs go to 0 immediately;
  - after release, MTLO 0xA5 → `lo`=0xA5.
  - With `HILO_DIVZERO_SKIP_EN` defined, DIV by 0 → no stall and no `au_start`.
